// File: rtl/ex_muldiv_pkg.sv
// Shared types and op-code helpers for the EX-stage multiply/divide unit.
package ex_muldiv_pkg;

    // Op codes driven by decode on op_i.
    typedef enum logic [2:0] {
        MD_OP_MULT  = 3'd0,
        MD_OP_MULTU = 3'd1,
        MD_OP_MADD  = 3'd2,
        MD_OP_MADDU = 3'd3,
        MD_OP_MSUB  = 3'd4,
        MD_OP_MSUBU = 3'd5,
        MD_OP_DIV   = 3'd6,
        MD_OP_DIVU  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    // What a multiply-class op does with the old {HI,LO}.
    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_ADD  = 2'd1,
        ACC_SUB  = 2'd2
    } acc_e;

    function automatic logic op_is_div(input md_op_e op);
        return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input md_op_e op);
        return (op == MD_OP_MULT) || (op == MD_OP_MADD) ||
               (op == MD_OP_MSUB) || (op == MD_OP_DIV);
    endfunction

    function automatic acc_e op_acc(input md_op_e op);
        case (op)
            MD_OP_MADD, MD_OP_MADDU: return ACC_ADD;
            MD_OP_MSUB, MD_OP_MSUBU: return ACC_SUB;
            default:                 return ACC_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ex_div_core.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per step.
// quot_o/rem_o present the values the current step produces, so the owner can
// capture the final result on the same edge as the last step.
module ex_div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            init_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quot_o,
    output logic [XLEN-1:0] rem_o
);

    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] div_q;

    logic [XLEN:0]   shifted;
    logic            fits;
    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] quo_nx;

    // One restoring step: shift the next dividend bit in, subtract if it fits.
    // When it fits the true difference is below the divisor, so an XLEN-bit
    // modulo subtraction is exact.
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        fits    = (shifted >= {1'b0, div_q});
        rem_nx  = fits ? (shifted[XLEN-1:0] - div_q) : shifted[XLEN-1:0];
        quo_nx  = {quo_q[XLEN-2:0], fits};
    end

    assign quot_o = quo_nx;
    assign rem_o  = rem_nx;

    // Divider state: loaded on init, advanced one bit per step.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            div_q <= '0;
        end else if (init_i) begin
            quo_q <= dividend_i;
            rem_q <= '0;
            div_q <= divisor_i;
        end else if (step_i) begin
            quo_q <= quo_nx;
            rem_q <= rem_nx;
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multi-cycle MUL / MADD / MSUB / DIV unit producing a HI/LO pair.
// The FSM accepts an op from IDLE, stalls the pipe while BUSY, and presents a
// one-cycle registered result in DONE.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] opa_i,
    input  logic [XLEN-1:0] opb_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic            annul_i,
    output logic            stallreq_o,
    output logic            done_o,
    output logic            whilo_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o,
    output logic            div_by_zero_o
);

    localparam int CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    md_state_e         state_q;
    md_op_e            op_q;
    logic              sign_a_q;
    logic              sign_b_q;
    logic [XLEN-1:0]   mag_a_q;
    logic [XLEN-1:0]   mag_b_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              done_q;
    logic              dbz_q;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;

    md_op_e            op_in;
    logic              in_signed;
    logic              sign_a_in;
    logic              sign_b_in;
    logic [XLEN-1:0]   mag_a_in;
    logic [XLEN-1:0]   mag_b_in;
    logic              div_zero_in;
    logic              accept;

    logic [XLEN-1:0]   div_quot;
    logic [XLEN-1:0]   div_rem;

    logic [2*XLEN-1:0] prod_mag;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] mul_res;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   hi_d;
    logic [XLEN-1:0]   lo_d;

    // Operand decode at acceptance: signs only matter for the signed ops.
    assign op_in       = md_op_e'(op_i);
    assign in_signed   = op_is_signed(op_in);
    assign sign_a_in   = in_signed & opa_i[XLEN-1];
    assign sign_b_in   = in_signed & opb_i[XLEN-1];
    assign mag_a_in    = sign_a_in ? -opa_i : opa_i;
    assign mag_b_in    = sign_b_in ? -opb_i : opb_i;
    assign div_zero_in = op_is_div(op_in) && (opb_i == '0);
    assign accept      = (state_q == ST_IDLE) && start_i && !annul_i;

    ex_div_core #(
        .XLEN (XLEN)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .init_i     (accept && op_is_div(op_in) && !div_zero_in),
        .step_i     ((state_q == ST_BUSY) && op_is_div(op_q)),
        .dividend_i (mag_a_in),
        .divisor_i  (mag_b_in),
        .quot_o     (div_quot),
        .rem_o      (div_rem)
    );

    // Result datapath: sign-fixed product with optional accumulate, or
    // sign-fixed quotient/remainder from the divider's final step.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves a value unassigned and infers a latch.
        prod_mag = {{XLEN{1'b0}}, mag_a_q} * {{XLEN{1'b0}}, mag_b_q};
        prod     = (sign_a_q ^ sign_b_q) ? -prod_mag : prod_mag;
        mul_res  = prod;
        case (op_acc(op_q))
            ACC_ADD: mul_res = acc_q + prod;
            ACC_SUB: mul_res = acc_q - prod;
            default: mul_res = prod;
        endcase
        quot_fix = (sign_a_q ^ sign_b_q) ? -div_quot : div_quot;
        rem_fix  = sign_a_q ? -div_rem : div_rem;
        if (op_is_div(op_q)) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
        end else begin
            {hi_d, lo_d} = mul_res;
        end
    end

    // Control FSM with latched operands, latency counter and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= MD_OP_MULT;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    dbz_q  <= 1'b0;
                    hi_q   <= '0;
                    lo_q   <= '0;
                    if (accept) begin
                        op_q     <= op_in;
                        sign_a_q <= sign_a_in;
                        sign_b_q <= sign_b_in;
                        mag_a_q  <= mag_a_in;
                        mag_b_q  <= mag_b_in;
                        acc_q    <= {hi_i, lo_i};
                        if (div_zero_in) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            dbz_q   <= 1'b1;
                            hi_q    <= opa_i;
                            lo_q    <= '1;
                        end else begin
                            state_q <= ST_BUSY;
                            cnt_q   <= op_is_div(op_in) ? CNT_W'(XLEN - 1)
                                                        : CNT_W'(MUL_LAT - 1);
                        end
                    end
                end
                ST_BUSY: begin
                    if (annul_i) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == '0) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    // start_i is still high for the same instruction here.
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    dbz_q   <= 1'b0;
                    hi_q    <= '0;
                    lo_q    <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    dbz_q   <= 1'b0;
                end
            endcase
        end
    end

    // A flush in DONE suppresses the commit in the same cycle.
    assign done_o        = done_q & ~annul_i;
    assign whilo_o       = done_o;
    assign hi_o          = done_o ? hi_q : '0;
    assign lo_o          = done_o ? lo_q : '0;
    assign div_by_zero_o = dbz_q & done_o;
    assign stallreq_o    = accept || (state_q == ST_BUSY);

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed scenarios plus random ops
// against a plain-arithmetic reference model.
module tb_ex_muldiv;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = 2;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MADD  = 3'd2;
    localparam logic [2:0] OP_MADDU = 3'd3;
    localparam logic [2:0] OP_MSUB  = 3'd4;
    localparam logic [2:0] OP_MSUBU = 3'd5;
    localparam logic [2:0] OP_DIV   = 3'd6;
    localparam logic [2:0] OP_DIVU  = 3'd7;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] opa_i, opb_i, hi_i, lo_i;
    logic            annul_i;
    logic            stallreq_o, done_o, whilo_o, div_by_zero_o;
    logic [XLEN-1:0] hi_o, lo_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_muldiv #(
        .XLEN    (XLEN),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .op_i          (op_i),
        .opa_i         (opa_i),
        .opb_i         (opb_i),
        .hi_i          (hi_i),
        .lo_i          (lo_i),
        .annul_i       (annul_i),
        .stallreq_o    (stallreq_o),
        .done_o        (done_o),
        .whilo_o       (whilo_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o),
        .div_by_zero_o (div_by_zero_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference result {div_by_zero, HI, LO} from plain 64-bit arithmetic.
    function automatic logic [64:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
        logic [63:0] acc;
        logic [63:0] ps;
        logic [63:0] pu;
        longint      sa, sb, q, r;
        acc = {hi, lo};
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ps  = 64'(sa * sb);
        pu  = {32'd0, a} * {32'd0, b};
        case (op)
            OP_MULT:  return {1'b0, ps};
            OP_MULTU: return {1'b0, pu};
            OP_MADD:  return {1'b0, acc + ps};
            OP_MADDU: return {1'b0, acc + pu};
            OP_MSUB:  return {1'b0, acc - ps};
            OP_MSUBU: return {1'b0, acc - pu};
            OP_DIV: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    function automatic int latency(input logic [2:0] op, input logic [31:0] b);
        if (op == OP_DIV || op == OP_DIVU) return (b == 0) ? 1 : XLEN + 1;
        return MUL_LAT + 1;
    endfunction

    // Launch one op, hold start through DONE, check every cycle until the
    // cycle after DONE. Operand inputs are scrambled once the op is accepted.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
        logic [64:0] exp;
        int          lat;
        exp = model(op, a, b, hi, lo);
        lat = latency(op, b);
        @(posedge clk); #1;
        start_i = 1'b1; annul_i = 1'b0; op_i = op;
        opa_i = a; opb_i = b; hi_i = hi; lo_i = lo;
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            check({tag, "_stall"}, stallreq_o, (k < lat));
            check({tag, "_done"}, done_o, (k == lat));
            if (k == lat) begin
                check({tag, "_hi"}, hi_o, exp[63:32]);
                check({tag, "_lo"}, lo_o, exp[31:0]);
                check({tag, "_whilo"}, whilo_o, 1);
                check({tag, "_dbz"}, div_by_zero_o, exp[64]);
            end else begin
                check({tag, "_hi_idle"}, hi_o, 0);
            end
            @(posedge clk); #1;
            if (k == 0) begin
                opa_i = $urandom; opb_i = $urandom; hi_i = $urandom; lo_i = $urandom;
            end
        end
        start_i = 1'b0;
        @(negedge clk);
        check({tag, "_after_done"}, done_o, 0);
        check({tag, "_after_stall"}, stallreq_o, 0);
        check({tag, "_after_lo"}, lo_o, 0);
    endtask

    // Flush arriving in the DONE cycle must suppress the commit immediately.
    task automatic annul_in_done(input string tag, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
        int lat;
        lat = latency(op, b);
        @(posedge clk); #1;
        start_i = 1'b1; annul_i = 1'b0; op_i = op; opa_i = a; opb_i = b;
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            check({tag, "_pre_done"}, done_o, 0);
            @(posedge clk); #1;
        end
        annul_i = 1'b1;
        @(negedge clk);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_whilo"}, whilo_o, 0);
        check({tag, "_dbz"}, div_by_zero_o, 0);
        check({tag, "_hi"}, hi_o, 0);
        check({tag, "_lo"}, lo_o, 0);
        @(posedge clk); #1;
        annul_i = 1'b0; start_i = 1'b0;
        @(negedge clk);
        check({tag, "_idle_stall"}, stallreq_o, 0);
        check({tag, "_idle_done"}, done_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] specials [5];
        logic [31:0] ra, rb;
        logic [2:0]  rop;
        specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_i = '0;
        opa_i = '0; opb_i = '0; hi_i = '0; lo_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_done", done_o, 0);
        check("reset_stall", stallreq_o, 0);
        check("reset_whilo", whilo_o, 0);
        check("reset_hi", hi_o, 0);
        check("reset_lo", lo_o, 0);
        check("reset_dbz", div_by_zero_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed scenarios.
        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'd0, 32'd0);
        run_op("maddu_carry", OP_MADDU, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF);
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0);
        run_op("divu_small", OP_DIVU, 32'd7, 32'd2, 32'd0, 32'd0);
        run_op("divu_zero", OP_DIVU, 32'd5, 32'd0, 32'd0, 32'd0);
        run_op("div_zero", OP_DIV, 32'h8000_0001, 32'd0, 32'd0, 32'd0);
        run_op("div_minneg", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0);
        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
        run_op("msubu", OP_MSUBU, 32'd3, 32'd5, 32'd0, 32'd4);

        // Annul mid-divide, then a back-to-back MSUB in the very next cycle.
        @(posedge clk); #1;
        start_i = 1'b1; op_i = OP_DIV; opa_i = 32'd100; opb_i = 32'd3;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("annul_busy_stall", stallreq_o, 1);
            check("annul_busy_done", done_o, 0);
            @(posedge clk); #1;
        end
        annul_i = 1'b1;
        @(negedge clk);
        check("annul_cycle_done", done_o, 0);
        run_op("msub_after_annul", OP_MSUB, 32'd3, 32'd4, 32'd0, 32'd10);

        annul_in_done("annul_done_mul", OP_MULT, 32'd5, 32'd6);
        annul_in_done("annul_done_dbz", OP_DIVU, 32'd9, 32'd0);

        // Annul in IDLE blocks acceptance: no stall and no result later.
        @(posedge clk); #1;
        start_i = 1'b1; annul_i = 1'b1; op_i = OP_MULT; opa_i = 32'd2; opb_i = 32'd2;
        @(negedge clk);
        check("annul_idle_stall", stallreq_o, 0);
        @(posedge clk); #1;
        start_i = 1'b0; annul_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("annul_idle_no_done", done_o, 0);
            check("annul_idle_no_stall", stallreq_o, 0);
        end

        // Reset mid-BUSY returns to IDLE with all outputs low.
        @(posedge clk); #1;
        start_i = 1'b1; op_i = OP_DIV; opa_i = 32'd1000; opb_i = 32'd7;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1; start_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_busy_stall", stallreq_o, 0);
            check("rst_busy_done", done_o, 0);
            check("rst_busy_hi", hi_o, 0);
            check("rst_busy_dbz", div_by_zero_o, 0);
        end
        run_op("after_rst", OP_MADD, 32'hFFFF_FFFF, 32'd9, 32'h1234_5678, 32'h0000_0004);

        // Random ops, with corner operand values mixed in.
        for (int n = 0; n < 30; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            run_op("rand", rop, ra, rb, $urandom, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
